pulse_logic_cell: RTL

Parametrised clocked pulse-logic cell model, the generalised successor of the two-input clocked XOR cell. It runs on one synchronous system clock and takes N toggle-encoded data channels plus a toggle-encoded pulse clock. It evaluates a selectable XOR/OR/AND function on each pulse-clock event and emits a delayed output toggle. Inter-event spacing is checked against a hold window and violations are counted. It sits alongside the other cell models feeding the VCD timing-assertion flow.

---
 rtl/pulse_cell_pkg.sv | 28 ++
 rtl/pulse_logic_cell_if.sv | 25 ++
 rtl/pulse_edge_detect.sv | 30 +++
 rtl/pulse_logic_cell.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_cell_pkg.sv
// Shared types for the clocked pulse-logic cell: function select, FSM states
// and a width helper used to size source ids, timers and counters.
package pulse_cell_pkg;

    typedef enum logic [1:0] {
        MODE_XOR  = 2'd0,
        MODE_OR   = 2'd1,
        MODE_AND  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ARMED = 2'd2
    } state_e;

    // Bits needed to encode values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pulse_logic_cell_if.sv
// Bundle of the toggle-encoded inputs and the cell's status outputs.
interface pulse_logic_cell_if
    import pulse_cell_pkg::*;
#(
    parameter int N_IN    = 2,
    parameter int COUNT_W = 8
);
    mode_e               mode;
    logic [N_IN-1:0]     in_tgl;
    logic                pclk_tgl;
    logic                out_tgl;
    logic                violation;
    logic [COUNT_W-1:0]  viol_count;
    logic                busy;

    modport master (
        output mode, in_tgl, pclk_tgl,
        input  out_tgl, violation, viol_count, busy
    );

    modport slave (
        input  mode, in_tgl, pclk_tgl,
        output out_tgl, violation, viol_count, busy
    );
endinterface

// File: rtl/pulse_edge_detect.sv
// Vectored toggle-to-event converter: one sync stage plus a previous-value
// register; while tracking, both follow the inputs and no events are produced.
module pulse_edge_detect #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         track_i,
    input  logic [W-1:0] tgl_i,
    output logic [W-1:0] evt_o
);
    logic [W-1:0] sync_q;
    logic [W-1:0] prev_q;

    // Loading prev from the raw input while tracking leaves sync and prev
    // equal on the first enabled cycle, so the settle period never leaks
    // a stale event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= tgl_i;
            prev_q <= track_i ? tgl_i : sync_q;
        end
    end

    assign evt_o = track_i ? '0 : (sync_q ^ prev_q);

endmodule

// File: rtl/pulse_logic_cell.sv
// Clocked pulse-logic cell: accumulates data pulses, evaluates XOR/OR/AND on
// each pulse-clock event, delays the result and polices inter-event spacing.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | post-reset settle, START cycles, inputs tracked, no events
// ST_IDLE  | nothing accumulated since the last pulse-clock event
// ST_ARMED | at least one data event accumulated, mode latched
module pulse_logic_cell
    import pulse_cell_pkg::*;
#(
    parameter int N_IN      = 2,
    parameter int HOLD      = 3,
    parameter int OUT_DELAY = 5,
    parameter int START     = 8,
    parameter int COUNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    pulse_logic_cell_if.slave bus
);
    localparam int SRC_W  = clog2(N_IN + 1);
    localparam int TMR_W  = clog2(HOLD + 1);
    localparam int INIT_W = clog2(START);
    localparam logic [N_IN:0] EV_ONE = {{N_IN{1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [INIT_W-1:0]    init_cnt_q, init_cnt_d;
    mode_e                mode_q, mode_d;
    logic                 parity_q, parity_d;
    logic                 flag_q, flag_d;
    logic [N_IN-1:0]      mask_q, mask_d;
    logic [OUT_DELAY-1:0] pipe_q, pipe_d;
    logic                 out_q, out_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [SRC_W-1:0]     last_src_q, last_src_d;
    logic                 viol_q, viol_d;
    logic [COUNT_W-1:0]   count_q, count_d;

    logic                 track;
    logic [N_IN:0]        ev_all;
    logic [N_IN-1:0]      data_ev;
    logic                 pclk_ev;
    logic                 any_ev;
    logic                 multi_ev;
    logic [SRC_W-1:0]     new_src;
    logic                 par_acc;
    logic                 flag_acc;
    logic [N_IN-1:0]      mask_acc;
    mode_e                eff_mode;
    logic                 fire;

    assign track = (state_q == ST_INIT);

    // Pulse clock rides as the top bit so its source id is N_IN.
    pulse_edge_detect #(
        .W (N_IN + 1)
    ) u_edge (
        .clk     (clk),
        .rst     (rst),
        .track_i (track),
        .tgl_i   ({bus.pclk_tgl, bus.in_tgl}),
        .evt_o   (ev_all)
    );

    assign data_ev = ev_all[N_IN-1:0];
    assign pclk_ev = ev_all[N_IN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= INIT_W'(START - 1);
            mode_q     <= MODE_XOR;
            parity_q   <= 1'b0;
            flag_q     <= 1'b0;
            mask_q     <= '0;
            pipe_q     <= '0;
            out_q      <= 1'b0;
            timer_q    <= '0;
            last_src_q <= '0;
            viol_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            mode_q     <= mode_d;
            parity_q   <= parity_d;
            flag_q     <= flag_d;
            mask_q     <= mask_d;
            pipe_q     <= pipe_d;
            out_q      <= out_d;
            timer_q    <= timer_d;
            last_src_q <= last_src_d;
            viol_q     <= viol_d;
            count_q    <= count_d;
        end
    end

    // Same-cycle data events are folded in before evaluation; in IDLE the
    // live mode applies because nothing has been latched yet.
    always_comb begin
        par_acc  = parity_q ^ (^data_ev);
        flag_acc = flag_q | (|data_ev);
        mask_acc = mask_q | data_ev;
        eff_mode = (state_q == ST_ARMED) ? mode_q : bus.mode;
        fire     = par_acc;
        case (eff_mode)
            MODE_OR:  fire = flag_acc;
            MODE_AND: fire = &mask_acc;
            default:  fire = par_acc;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        mode_d     = mode_q;
        parity_d   = parity_q;
        flag_d     = flag_q;
        mask_d     = mask_q;
        pipe_d     = pipe_q << 1;
        out_d      = out_q ^ pipe_q[OUT_DELAY-1];

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q - INIT_W'(1);
                end
            end
            ST_IDLE, ST_ARMED: begin
                if (pclk_ev) begin
                    pipe_d[0] = fire;
                    parity_d  = 1'b0;
                    flag_d    = 1'b0;
                    mask_d    = '0;
                    state_d   = ST_IDLE;
                end else if (|data_ev) begin
                    parity_d = par_acc;
                    flag_d   = flag_acc;
                    mask_d   = mask_acc;
                    state_d  = ST_ARMED;
                    if (state_q == ST_IDLE) begin
                        mode_d = bus.mode;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Hold window: several sources in one cycle always violate; a lone
    // event violates only if it comes from a new source inside the window.
    always_comb begin
        new_src = '0;
        for (int i = 0; i <= N_IN; i++) begin
            if (ev_all[i]) begin
                new_src = SRC_W'(i);
            end
        end
        any_ev     = |ev_all;
        multi_ev   = (ev_all & (ev_all - EV_ONE)) != '0;
        viol_d     = any_ev && (multi_ev || ((timer_q != '0) && (new_src != last_src_q)));
        timer_d    = timer_q;
        last_src_d = last_src_q;
        if (any_ev) begin
            timer_d    = TMR_W'(HOLD);
            last_src_d = new_src;
        end else if (timer_q != '0) begin
            timer_d = timer_q - TMR_W'(1);
        end
        count_d = count_q;
        if (viol_d && (count_q != '1)) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    assign bus.out_tgl    = out_q;
    assign bus.violation  = viol_q;
    assign bus.viol_count = count_q;
    assign bus.busy       = (state_q == ST_ARMED);

endmodule
